// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if
// Groups the frame_scheduler handshake and status signals.
//   master : environment side (sync generator, game logic units, debug host);
//            drives frame_end/enable/clear_flags/unit_done and observes status.
//   slave  : the scheduler itself.
// Signals:
//   frame_end    one-cycle pulse per frame from the sync generator
//   enable       sequencing enable
//   clear_flags  one-cycle pulse clearing the sticky error flags
//   unit_done    per-unit done (pulse or level)
//   unit_start   one-hot start pulse, one cycle wide
//   busy         sequence in progress
//   active_unit  index of the unit started or awaited, 0 when idle
//   update_done  one-cycle pulse when a sequence completes
//   frame_count  completed sequences, wraps at 256
//   overrun      sticky: a launch was due while busy
//   timeout_err  sticky per-unit timeout flags
interface frame_scheduler_if #(
  parameter int NUM_UNITS = 4
) ();
  logic                 frame_end;
  logic                 enable;
  logic                 clear_flags;
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0] unit_start;
  logic                 busy;
  logic [2:0]           active_unit;
  logic                 update_done;
  logic [7:0]           frame_count;
  logic                 overrun;
  logic [NUM_UNITS-1:0] timeout_err;

  modport master (
    output frame_end, enable, clear_flags, unit_done,
    input  unit_start, busy, active_unit, update_done, frame_count,
           overrun, timeout_err
  );

  modport slave (
    input  frame_end, enable, clear_flags, unit_done,
    output unit_start, busy, active_unit, update_done, frame_count,
           overrun, timeout_err
  );
endinterface

// File: rtl/frame_scheduler.sv
// frame_scheduler
// Per-frame sequencer for the game logic units. Every FRAME_DIV enabled
// frame_end pulses it starts each unit in turn (start/done handshake), with a
// per-unit cycle timeout, then pulses update_done and bumps frame_count.
// Ports:
//   clk    pixel clock (same as the sync generator)
//   reset  asynchronous, active-low reset
//   bus    frame_scheduler_if.slave (see interface for the signal list)
// Parameters: NUM_UNITS (1..8), TIMEOUT (2..65535), FRAME_DIV (1..16).
module frame_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 1024,
  parameter int FRAME_DIV = 1
) (
  input logic              clk,
  input logic              reset,
  frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [3:0]           DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [15:0]          TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [2:0]           IDX_LAST = 3'(NUM_UNITS - 1);
  localparam logic [NUM_UNITS-1:0] ONE      = NUM_UNITS'(1);

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          timer_q, timer_d;
  logic [3:0]           div_q, div_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic                 ovr_q, ovr_d;
  logic [NUM_UNITS-1:0] terr_q, terr_d;

  logic                 launch_due;
  logic                 done_sel;
  logic [NUM_UNITS-1:0] idx_onehot;
  logic [NUM_UNITS-1:0] terr_set;

  assign idx_onehot = ONE << idx_q;
  // Only the awaited unit's done bit matters; stray done bits are masked off.
  assign done_sel   = |(bus.unit_done & idx_onehot);

  // Frame divider: counts enabled frame_end pulses, held at 0 while disabled.
  always_comb begin
    div_d      = div_q;
    launch_due = 1'b0;
    if (!bus.enable) begin
      div_d = '0;
    end else if (bus.frame_end) begin
      if (div_q == DIV_LAST) begin
        launch_due = 1'b1;
        div_d      = '0;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  // Sequencer next state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    fcnt_d   = fcnt_q;
    terr_set = '0;
    case (state_q)
      IDLE: begin
        if (launch_due) begin
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_sel || (timer_q == TMO_LAST)) begin
          if (!done_sel) terr_set = idx_onehot;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = START;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DONE: begin
        fcnt_d  = fcnt_q + 8'd1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as clear_flags wins.
  always_comb begin
    ovr_d  = (ovr_q & ~bus.clear_flags) | (launch_due & (state_q != IDLE));
    terr_d = (terr_q & ~{NUM_UNITS{bus.clear_flags}}) | terr_set;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      div_q   <= '0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
      terr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
      terr_q  <= terr_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign bus.unit_start  = (state_q == START) ? idx_onehot : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.active_unit = idx_q;
  assign bus.update_done = (state_q == DONE);
  assign bus.frame_count = fcnt_q;
  assign bus.overrun     = ovr_q;
  assign bus.timeout_err = terr_q;

endmodule
